spike_event_packetizer: RTL and testbench
=========================================

Name: spike_event_packetizer

Overview:
- Consumer-side companion to the processing system: watches the per-unit spike_detection_array and event_out_array outputs and turns each detected spike into a timestamped 3-byte packet.
- Packets leave on a byte-wide valid/ready stream toward the chip I/O or a serial transmitter.
- Short spike bursts are absorbed by per-unit capture slots and a small FIFO.
- Drops are reported through a sticky overflow flag and a saturating drop counter.

Parameters:
- NUM_UNITS, 4, number of detection units (1..16).
- FIFO_DEPTH, 4, packet FIFO entries (power of two, >=2).
- TS_WIDTH, 16, timestamp counter width (fixed 16 for packet format).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spike_detection_array  input  NUM_UNITS  per-unit spike level, bit u = unit u
- event_out_array  input  2*NUM_UNITS  per-unit event code, bits [2u+1:2u] = unit u
- clear_status  input  1  synchronous clear of overflow and drop_count
- out_data  output  8  packet byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts byte at posedge when out_valid=1
- overflow  output  1  sticky: at least one event dropped
- drop_count  output  8  dropped events, saturates at 255

Behaviour:
- Reset (rst_n=0, async): all outputs 0 (out_data, out_valid, overflow, drop_count); ts counter, edge history, pending mask, FIFO pointers cleared; FSM in IDLE.
- Timestamp: free-running TS_WIDTH counter, +1 every clk, wraps 0xFFFF->0x0000.
- Edge detect: unit u captures at posedge where spike[u]=1 and previous sampled spike[u]=0. A held-high level yields one capture.
- Capture: sets pending[u]; stores {event_out_array[2u+1:2u], ts} as sampled at that edge into slot u.
- Capture while pending[u] already set: new event dropped; slot keeps the old one.
- Arbiter: each cycle, if FIFO not full, pushes the lowest-index pending unit as {unit[3:0], code[1:0], ts[15:0]} and clears its pending bit. Capture and push of the same unit on one edge: push the old slot, keep pending set with the new data.
- FIFO full: pending bits wait; no drop until a second rising edge arrives on the same unit.
- Drop handling: each dropped event sets overflow; drop_count increments, saturating at 255.
- clear_status: clears overflow and drop_count. A drop on the same edge as clear_status wins: overflow=1, drop_count=1.
- Packet format: byte0={2'b10, code[1:0], unit[3:0]}, byte1=ts[15:8], byte2=ts[7:0].
- Output FSM states: IDLE, B0, B1, B2.
  - IDLE: FIFO non-empty -> pop head into holding register, go B0.
  - B0/B1: out_valid=1; out_ready -> next state.
  - B2: out_valid=1; out_ready -> pop and go B0 if FIFO non-empty (back-to-back), else IDLE.
- Stream rule: out_data and out_valid stay stable while out_valid=1 and out_ready=0. out_valid is 0 only in IDLE.
- Latency: rising edge captured at posedge E0, pushed at E1, loaded at E2. byte0 valid right after E2, i.e. 2 cycles after capture with an empty pipeline.
- Throughput: 1 packet per 3 cycles with out_ready held high.
- Simultaneous captures on several units: packets emitted in ascending unit order, each with the shared timestamp.
- Reset mid-packet: packet abandoned; out_valid drops asynchronously.

Test Plan:
- Single event: after reset, spike[2]=1 with event code 2'b01, one cycle, captured at ts=0x0010 -> bytes 0x92, 0x00, 0x10. out_valid first rises 2 cycles after capture; 3 accepts with out_ready=1.
- Simultaneous: spike=4'b1011 in one cycle, codes u0=3, u1=0, u3=2, ts=0x0020 -> packets for units 0, 1, 3 in order: 0xB0/0x00/0x20, 0x81/0x00/0x20, 0xA3/0x00/0x20. Back-to-back, no IDLE gap.
- Backpressure: out_ready=0 for 5 cycles mid-packet (in B1) -> out_data held at 0x00, out_valid held at 1. Packet resumes intact when out_ready=1.
- Overflow: out_ready=0, unit 0 pulsed 7 times on separate edges (FIFO_DEPTH=4: 4 FIFO + 1 slot) -> overflow=1, drop_count=2. After drain: 5 packets with increasing timestamps. Then clear_status -> 0/0.
- Held level: spike[1] high for 10 cycles -> exactly one packet.
- Timestamp wrap and reset: capture at ts=0xFFFF then 0x0000 -> byte pairs FF/FF then 00/00. Assert rst_n=0 during B1 -> out_valid=0 immediately; no residual packet after release.

Source files
------------

// File: rtl/spike_event_packetizer.sv
// Spike event packetizer: turns rising edges on per-unit spike lines into timestamped
// 3-byte packets, buffered through per-unit slots and a small FIFO onto a byte stream.
module spike_event_packetizer #(
    parameter int NUM_UNITS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_UNITS-1:0]   spike_detection_array,
    input  logic [2*NUM_UNITS-1:0] event_out_array,
    input  logic                   clear_status,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int PKT_W = 6 + TS_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_W = $clog2(NUM_UNITS + 1);

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    logic [TS_WIDTH-1:0]  r_ts;
    logic [NUM_UNITS-1:0] r_spikePrev;
    logic [NUM_UNITS-1:0] r_pending;
    logic [1:0]           r_slotCode [NUM_UNITS];
    logic [TS_WIDTH-1:0]  r_slotTs   [NUM_UNITS];
    logic [PKT_W-1:0]     r_fifoMem  [FIFO_DEPTH];
    logic [PTR_W:0]       r_wrPtr;
    logic [PTR_W:0]       r_rdPtr;
    logic [PKT_W-1:0]     r_hold;
    state_t               r_state;

    logic [NUM_UNITS-1:0] w_rise;
    logic [NUM_UNITS-1:0] w_pushMask;
    logic [NUM_UNITS-1:0] w_drop;
    logic [IDX_W-1:0]     w_pushSel;
    logic                 w_anyPend;
    logic                 w_push;
    logic [PKT_W-1:0]     w_pushPkt;
    logic                 w_fifoFull;
    logic                 w_fifoEmpty;
    logic                 w_pop;
    state_t               w_nextState;
    logic [CNT_W-1:0]     w_dropNum;
    logic [7:0]           w_cntBase;
    logic [8:0]           w_cntSum;

    assign w_rise      = spike_detection_array & ~r_spikePrev;
    assign w_fifoEmpty = (r_wrPtr == r_rdPtr);
    assign w_fifoFull  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                         (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_spikePrev <= '0;
        end else begin
            r_ts        <= r_ts + TS_WIDTH'(1);
            r_spikePrev <= spike_detection_array;
        end
    end

    // Fixed priority: the descending scan leaves the lowest pending index selected.
    always_comb begin
        w_pushSel = '0;
        w_anyPend = 1'b0;
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (r_pending[u]) begin
                w_pushSel = IDX_W'(u);
                w_anyPend = 1'b1;
            end
        end
    end

    assign w_push    = w_anyPend && !w_fifoFull;
    assign w_pushPkt = {4'(w_pushSel), r_slotCode[w_pushSel], r_slotTs[w_pushSel]};

    always_comb begin
        w_pushMask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_pushMask[u] = w_push && (w_pushSel == IDX_W'(u));
        end
    end

    // A slot being drained this edge may take a new capture; otherwise a busy slot drops it.
    assign w_drop = w_rise & r_pending & ~w_pushMask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_slotCode[u] <= '0;
                r_slotTs[u]   <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_rise[u] && !w_drop[u]) begin
                    r_pending[u]  <= 1'b1;
                    r_slotCode[u] <= event_out_array[2*u +: 2];
                    r_slotTs[u]   <= r_ts;
                end else if (w_pushMask[u]) begin
                    r_pending[u] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_dropNum = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_dropNum = w_dropNum + CNT_W'(w_drop[u]);
        end
    end

    assign w_cntBase = clear_status ? 8'h00 : drop_count;
    assign w_cntSum  = {1'b0, w_cntBase} + 9'(w_dropNum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            overflow   <= (|w_drop) || (overflow && !clear_status);
            drop_count <= (w_cntSum > 9'd255) ? 8'hFF : w_cntSum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr[PTR_W-1:0]] <= w_pushPkt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_nextState = B0;
                end
            end
            B0: if (out_ready) w_nextState = B1;
            B1: if (out_ready) w_nextState = B2;
            B2: begin
                if (out_ready) begin
                    if (!w_fifoEmpty) begin
                        w_pop       = 1'b1;
                        w_nextState = B0;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_pop) begin
                r_hold  <= r_fifoMem[r_rdPtr[PTR_W-1:0]];
                r_rdPtr <= r_rdPtr + (PTR_W + 1)'(1);
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (PTR_W + 1)'(1);
            end
        end
    end

    assign out_valid = (r_state != IDLE);

    always_comb begin
        out_data = 8'h00;
        unique case (r_state)
            IDLE: out_data = 8'h00;
            B0:   out_data = {2'b10, r_hold[TS_WIDTH+1:TS_WIDTH], r_hold[TS_WIDTH+5:TS_WIDTH+2]};
            B1:   out_data = r_hold[15:8];
            B2:   out_data = r_hold[7:0];
        endcase
    end

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Bench for spike_event_packetizer: directed scenarios plus random traffic, checked by a
// queue-based behavioural model feeding a byte scoreboard that a negedge monitor drains.
module tb_spike_event_packetizer;

    localparam int NU    = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] spike_detection_array;
    logic [7:0] event_out_array;
    logic       clear_status;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [7:0] drop_count;

    int total;
    int bad;

    // Behavioural model state: slots, FIFO occupancy, bytes left of the packet on the wire.
    int         mTs;
    logic [3:0] mPrev;
    bit         mPend   [NU];
    int         mCode   [NU];
    int         mSlotTs [NU];
    int         mFifoN;
    int         mLeft;
    bit         mOvf;
    int         mCnt;
    logic [7:0] expQ [$];

    spike_event_packetizer #(.NUM_UNITS(NU), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .spike_detection_array (spike_detection_array),
        .event_out_array       (event_out_array),
        .clear_status          (clear_status),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .overflow              (overflow),
        .drop_count            (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic modelReset();
        mTs    = 0;
        mPrev  = '0;
        mFifoN = 0;
        mLeft  = 0;
        mOvf   = 0;
        mCnt   = 0;
        for (int u = 0; u < NU; u++) begin
            mPend[u]   = 0;
            mCode[u]   = 0;
            mSlotTs[u] = 0;
        end
        expQ.delete();
    endtask

    task automatic pushPacket(input int unit, input int code, input int ts);
        expQ.push_back(8'(128 + code * 16 + unit));
        expQ.push_back(8'(ts / 256));
        expQ.push_back(8'(ts % 256));
    endtask

    // One clock edge of the reference behaviour, using the inputs the DUT just sampled.
    task automatic modelStep();
        int n;
        int drops;
        bit pushedOne;
        n         = mFifoN;
        drops     = 0;
        pushedOne = 0;
        if (mLeft == 0) begin
            if (n > 0) begin
                mLeft = 3;
                mFifoN--;
            end
        end else if (out_ready) begin
            mLeft--;
            if (mLeft == 0 && n > 0) begin
                mLeft = 3;
                mFifoN--;
            end
        end
        if (n < DEPTH) begin
            for (int u = 0; u < NU; u++) begin
                if (mPend[u] && !pushedOne) begin
                    pushedOne = 1;
                    pushPacket(u, mCode[u], mSlotTs[u]);
                    mFifoN++;
                    mPend[u] = 0;
                end
            end
        end
        for (int u = 0; u < NU; u++) begin
            if (spike_detection_array[u] && !mPrev[u]) begin
                if (mPend[u]) begin
                    drops++;
                end else begin
                    mPend[u]   = 1;
                    mCode[u]   = int'(event_out_array[2*u +: 2]);
                    mSlotTs[u] = mTs;
                end
            end
        end
        if (clear_status) begin
            mOvf = 0;
            mCnt = 0;
        end
        if (drops > 0) begin
            mOvf = 1;
            mCnt = (mCnt + drops > 255) ? 255 : mCnt + drops;
        end
        mPrev = spike_detection_array;
        mTs   = (mTs + 1) % 65536;
    endtask

    task automatic applyStimulus(input logic [3:0] sp, input logic [7:0] ev,
                                 input logic rdy, input logic clr);
        spike_detection_array = sp;
        event_out_array       = ev;
        out_ready             = rdy;
        clear_status          = clr;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput();
        checkVal("out_valid", int'(out_valid), int'(mLeft > 0));
        if (out_valid) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_byte: got=%0h want=none", out_data);
            end else begin
                checkVal("out_data", int'(out_data), int'(expQ[0]));
                if (out_ready) void'(expQ.pop_front());
            end
        end
        checkVal("overflow", int'(overflow), int'(mOvf));
        checkVal("drop_count", int'(drop_count), mCnt);
    endtask

    always @(negedge clk) begin
        if (rst_n) checkOutput();
    end

    task automatic idleUntil(input int target);
        int guard;
        guard = 0;
        while (mTs != target && guard < 70000) begin
            applyStimulus(4'h0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        if (mTs != target) begin
            total++;
            bad++;
            $display("[TB] FAIL ts_wait: got=%0h want=%0h", mTs, target);
        end
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(4'h0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        int guard;
        logic [3:0] sp;
        total = 0;
        bad   = 0;
        rst_n                 = 1'b0;
        spike_detection_array = '0;
        event_out_array       = '0;
        clear_status          = 1'b0;
        out_ready             = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checkVal("reset_valid", int'(out_valid), 0);
        checkVal("reset_data", int'(out_data), 0);
        checkVal("reset_overflow", int'(overflow), 0);
        checkVal("reset_drops", int'(drop_count), 0);

        // Single event on unit 2, code 1, captured at ts 0x0010.
        idleUntil(16);
        applyStimulus(4'b0100, 8'h10, 1'b1, 1'b0);
        idleCycles(8, 1'b1);

        // Simultaneous captures on units 0, 1, 3 sharing ts 0x0020.
        idleUntil(32);
        applyStimulus(4'b1011, 8'h83, 1'b1, 1'b0);
        idleCycles(14, 1'b1);

        // Backpressure while the second byte is on the wire.
        applyStimulus(4'b0010, 8'h0C, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(4'h0, 8'h00, 1'b1, 1'b0);
        idleCycles(5, 1'b0);
        idleCycles(6, 1'b1);

        // Held level yields a single packet.
        for (int i = 0; i < 10; i++) applyStimulus(4'b0010, 8'h04, 1'b1, 1'b0);
        idleCycles(8, 1'b1);

        // Overflow: a stalled unit-3 packet occupies the output, then 7 pulses on unit 0.
        applyStimulus(4'b1000, 8'h40, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4'b0001, 8'($urandom), 1'b0, 1'b0);
            applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0);
        end
        checkVal("ovf_flag", int'(overflow), 1);
        checkVal("ovf_count", int'(drop_count), 2);
        idleCycles(24, 1'b1);
        applyStimulus(4'h0, 8'h00, 1'b1, 1'b1);
        checkVal("clear_flag", int'(overflow), 0);
        checkVal("clear_count", int'(drop_count), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            sp = '0;
            for (int u = 0; u < NU; u++) sp[u] = ($urandom_range(0, 5) == 0);
            applyStimulus(sp, 8'($urandom), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 63) == 0));
        end
        guard = 0;
        while ((expQ.size() > 0 || mLeft > 0) && guard < 200) begin
            applyStimulus(4'h0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        if (expQ.size() > 0 || mLeft > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got=%0d want=0", expQ.size());
        end

        // Timestamp wrap: unit 0 at 0xFFFF, unit 1 at 0x0000.
        idleUntil(65535);
        applyStimulus(4'b0001, 8'h03, 1'b1, 1'b0);
        applyStimulus(4'b0010, 8'h04, 1'b1, 1'b0);
        applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0);
        guard = 0;
        while (mLeft != 2 && guard < 20) begin
            applyStimulus(4'h0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        if (mLeft != 2) begin
            total++;
            bad++;
            $display("[TB] FAIL reach_b1: got=%0d want=2", mLeft);
        end

        // Asynchronous reset in the middle of a packet.
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_valid", int'(out_valid), 0);
        checkVal("async_rst_data", int'(out_data), 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycles(12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
